btn_step_ctrl: RTL and testbench
================================

// Module: btn_step_ctrl
// PURPOSE
//  Multi-channel successor to the board-level single-step button logic.
//  - Debounces NUM_BTN raw push-buttons on a divided clock enable.
//  - Turns each debounced press into one instruction word: per-channel opcode prefix + switch operand.
//  - Buffers the words in a small FIFO and presents them to the sequencer over a valid/ready handshake.
//  - Sits between the board pins (sw, buttons) and seq; replaces the ad-hoc per-button stepping code.
// PARAMETERS
//  NUM_BTN    2   number of button channels (1..8)
//  DIV_W      17  clock-enable period = 2**DIV_W clk cycles (>= clog2(NUM_BTN)+1)
//  STABLE_N   3   consecutive equal samples needed to change a debounced level (>= 2)
//  INST_W     8   instruction word width
//  PFX_W      2   opcode prefix width; operand width = INST_W-PFX_W
//  FIFO_DEPTH 4   instruction FIFO entries (power of 2, >= 2)
//  CNT_W      8   accepted-instruction counter width
// PORTS
//  clk          in  1                clock, 100 MHz
//  rst_n        in  1                asynchronous active-low reset
//  i_btn        in  NUM_BTN          raw, unsynchronised buttons, active high
//  i_sw         in  INST_W-PFX_W     raw operand switches
//  i_prefix     in  NUM_BTN*PFX_W    static opcode prefix per channel; ch k = [k*PFX_W +: PFX_W]
//  o_inst       out INST_W           FIFO head word
//  o_inst_valid out 1                FIFO not empty
//  i_inst_ready in  1                sequencer accepts o_inst this cycle
//  o_btn_level  out NUM_BTN          debounced button levels
//  o_evt_cnt    out CNT_W            count of accepted instructions, wraps mod 2**CNT_W
//  o_overflow   out 1                sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst_n=0, async assert, sync release through 2-FF): all registers 0.
//    o_inst=0, o_inst_valid=0, o_btn_level=0, o_evt_cnt=0, o_overflow=0.
//  Divider
//    - DIV_W-bit free-running counter.
//    - clk_en is a 1-cycle pulse on the cycle the counter wraps to 0; first pulse 2**DIV_W cycles after reset release.
//  Sync: i_btn and i_sw each pass through 2 clk flops every cycle.
//  Operand latch: synced i_sw is registered into sw_q on clk_en only.
//  Debounce, per channel:
//    - On clk_en, shift the synced bit into a STABLE_N-bit history.
//    - All ones while level=0 -> level=1; all zeros while level=1 -> level=0; otherwise hold.
//    - Rising edge of level sets pend[k] on the following cycle. Release edges generate nothing.
//    - A button held through reset produces exactly one press after STABLE_N enables.
//  Arbitration
//    - Each cycle the lowest-index set pend bit is taken: push {prefix[k], sw_q}, clear pend[k].
//    - At most one push per cycle.
//    - Simultaneous presses drain in index order on consecutive cycles.
//    - No press is ever lost to arbitration.
//  FIFO: first-word fall-through; o_inst_valid = !empty; o_inst = head.
//    - Pop on o_inst_valid & i_inst_ready; o_evt_cnt increments on every pop.
//    - Push when full and no pop in the same cycle: word dropped, o_overflow <- 1, pend bit still cleared.
//    - Push and pop in the same cycle when full: both occur, no drop.
//    - Push and pop in the same cycle when empty: the word appears at the head next cycle; no bypass.
//    - i_inst_ready while empty: ignored.
//    - o_overflow clears only on reset.
//  Latency
//    - Raw edge to debounced level: 2 clk + (STABLE_N-1 .. STABLE_N) enable periods.
//    - Level rise to o_inst_valid: 3 clk when the FIFO is empty and no other channel is pending.
//  Pointers: clog2(FIFO_DEPTH)+1 bits each; full/empty from the MSB compare; pointers wrap naturally.
// TESTING (sim with DIV_W=2, STABLE_N=3, NUM_BTN=2, FIFO_DEPTH=4)
//  1. btn0 held high 40 cycles, sw=6'h15, prefix0=2'b00, ready=1
//     -> exactly one o_inst=8'h15 valid for 1 cycle; o_evt_cnt=1.
//  2. btn0 glitch high for 1 and 2 enable periods, then a 6-cycle bounce
//     -> no instruction; o_btn_level stays 0.
//  3. btn0 and btn1 rise on the same cycle, prefix1=2'b11, sw=6'h0A
//     -> 8'h0A then 8'hCA on consecutive heads; o_evt_cnt=2.
//  4. ready=0, 5 separate btn0 presses
//     -> 4 words queued, o_overflow=1 after the 5th.
//     Then ready=1: 4 pops in order, o_evt_cnt=4.
//  5. FIFO full and ready=1 on the same cycle a new push arrives
//     -> no drop; o_overflow stays 0; order preserved.
//  6. rst_n pulsed low mid-transfer with 2 words queued
//     -> o_inst_valid=0 immediately, o_evt_cnt=0.
//     btn still held -> one fresh press after STABLE_N enables.

Source files
------------

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: debounces raw buttons and queues one instruction word per press for the sequencer
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset, released through a 2-flop synchroniser
//   i_btn         raw push-buttons, active high, unsynchronised
//   i_sw          raw operand switches
//   i_prefix      static opcode prefix per channel, channel k at [k*PFX_W +: PFX_W]
//   o_inst        FIFO head word
//   o_inst_valid  FIFO not empty
//   i_inst_ready  sequencer accepts o_inst this cycle
//   o_btn_level   debounced button levels
//   o_evt_cnt     count of accepted instructions, wraps
//   o_overflow    sticky: a word was dropped on a full FIFO
module btn_step_ctrl #(
    parameter int NUM_BTN    = 2,
    parameter int DIV_W      = 17,
    parameter int STABLE_N   = 3,
    parameter int INST_W     = 8,
    parameter int PFX_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         i_btn,
    input  logic [INST_W-PFX_W-1:0]    i_sw,
    input  logic [NUM_BTN*PFX_W-1:0]   i_prefix,
    output logic [INST_W-1:0]          o_inst,
    output logic                       o_inst_valid,
    input  logic                       i_inst_ready,
    output logic [NUM_BTN-1:0]         o_btn_level,
    output logic [CNT_W-1:0]           o_evt_cnt,
    output logic                       o_overflow
);
    localparam int OP_W = INST_W - PFX_W;
    localparam int AW   = $clog2(FIFO_DEPTH);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [DIV_W-1:0]        r_div;
    logic                    r_en;
    logic [NUM_BTN-1:0]      r_btn_s1, r_btn_s2;
    logic [OP_W-1:0]         r_sw_s1, r_sw_s2, r_sw_q;
    logic [STABLE_N-1:0]     r_hist [NUM_BTN];
    logic [STABLE_N-1:0]     w_hist_nxt [NUM_BTN];
    logic [NUM_BTN-1:0]      r_level, r_level_d, r_pend, w_grant;
    logic [PFX_W-1:0]        w_pfx;
    logic                    r_push;
    logic [INST_W-1:0]       r_push_word;
    logic [INST_W-1:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wptr, r_rptr;
    logic                    w_empty, w_full, w_pop, w_wr, w_drop;
    logic [CNT_W-1:0]        r_evt;
    logic                    r_ovf;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Lowest-index pending channel wins; the rest wait for later cycles
    assign w_grant = r_pend & (-r_pend);

    always_comb begin
        for (int k = 0; k < NUM_BTN; k++)
            w_hist_nxt[k] = {r_hist[k][STABLE_N-2:0], r_btn_s2[k]};
        w_pfx = '0;
        for (int k = 0; k < NUM_BTN; k++)
            if (w_grant[k]) w_pfx = i_prefix[k*PFX_W +: PFX_W];
    end

    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && i_inst_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word
    assign w_wr    = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div       <= '0;
            r_en        <= 1'b0;
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_sw_q      <= '0;
            for (int k = 0; k < NUM_BTN; k++) r_hist[k] <= '0;
            r_level     <= '0;
            r_level_d   <= '0;
            r_pend      <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_evt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_div    <= r_div + DIV_W'(1);
            r_en     <= &r_div;
            r_btn_s1 <= i_btn;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= i_sw;
            r_sw_s2  <= r_sw_s1;
            if (r_en) begin
                r_sw_q <= r_sw_s2;
                for (int k = 0; k < NUM_BTN; k++) begin
                    r_hist[k]  <= w_hist_nxt[k];
                    r_level[k] <= (&w_hist_nxt[k]) ? 1'b1 : (|w_hist_nxt[k]) ? r_level[k] : 1'b0;
                end
            end
            r_level_d   <= r_level;
            // Only press edges request a word; the grant clears even if the word is later dropped
            r_pend      <= (r_pend & ~w_grant) | (r_level & ~r_level_d);
            r_push      <= |r_pend;
            r_push_word <= {w_pfx, r_sw_q};
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= r_push_word;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
                r_evt  <= r_evt + CNT_W'(1);
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign o_inst       = r_mem[r_rptr[AW-1:0]];
    assign o_inst_valid = !w_empty;
    assign o_btn_level  = r_level;
    assign o_evt_cnt    = r_evt;
    assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb_btn_step_ctrl: directed stimulus with a queue-based timing model checked every cycle
module tb_btn_step_ctrl;
    localparam int P     = 4;
    localparam int SN    = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] btn = '0;
    logic [5:0] sw = '0;
    logic [3:0] prefix = 4'b1100;
    logic       ready = 1'b0;
    logic [7:0] o_inst;
    logic       o_inst_valid;
    logic [1:0] o_btn_level;
    logic [7:0] o_evt_cnt;
    logic       o_overflow;

    btn_step_ctrl #(
        .NUM_BTN(2), .DIV_W(2), .STABLE_N(SN), .INST_W(8),
        .PFX_W(2), .FIFO_DEPTH(DEPTH), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn(btn), .i_sw(sw), .i_prefix(prefix),
        .o_inst(o_inst), .o_inst_valid(o_inst_valid), .i_inst_ready(ready),
        .o_btn_level(o_btn_level), .o_evt_cnt(o_evt_cnt), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: edge count since rst_n release, expected FIFO contents, press scheduling
    int         n;
    logic [7:0] q[$];
    int         m_cnt;
    bit         m_ovf;
    bit         m_level[2];
    bit         run_val[2];
    int         run_len[2];
    int         req_at[2];
    bit         ins_p;
    logic [7:0] ins_w;
    logic [5:0] m_swq, sw_d1, sw_d2;
    logic [1:0] btn_d1, btn_d2;
    bit         snap_v;
    logic [7:0] snap_inst;
    logic [7:0] popped[$];
    int         pop_n[$];
    int         nvalid;
    bit         lvl_seen;

    task model_clear();
        n = 0;
        q.delete();
        m_cnt = 0;
        m_ovf = 0;
        for (int k = 0; k < 2; k++) begin
            m_level[k] = 0;
            run_val[k] = 0;
            run_len[k] = 0;
            req_at[k]  = -1;
        end
        ins_p = 0;
        m_swq = '0;
        sw_d1 = '0;
        sw_d2 = '0;
        btn_d1 = '0;
        btn_d2 = '0;
        snap_v = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        bit full, pop, smp, done;
        if (!rst_n) model_clear();
        else begin
            n++;
            if (snap_v && ready) begin
                popped.push_back(snap_inst);
                pop_n.push_back(n);
            end
            nvalid += int'(snap_v);
            full = q.size() == DEPTH;
            pop  = q.size() > 0 && ready;
            if (pop) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (ins_p) begin
                if (full && !pop) m_ovf = 1;
                else q.push_back(ins_w);
            end
            ins_p = 0;
            done = 0;
            for (int k = 0; k < 2; k++)
                if (!done && req_at[k] >= 0 && req_at[k] <= n) begin
                    ins_p = 1;
                    ins_w = {prefix[k*2 +: 2], m_swq};
                    req_at[k] = -1;
                    done = 1;
                end
            // Debounce sample points: one every P edges, first one P+3 edges after release
            if (n >= P + 3 && (n - 3) % P == 0) begin
                m_swq = sw_d2;
                for (int k = 0; k < 2; k++) begin
                    smp = btn_d2[k];
                    if (smp == run_val[k]) run_len[k]++;
                    else begin
                        run_val[k] = smp;
                        run_len[k] = 1;
                    end
                    if (run_len[k] >= SN && m_level[k] != smp) begin
                        m_level[k] = smp;
                        if (smp) req_at[k] = n + 2;
                    end
                end
            end
            btn_d2 = btn_d1;
            btn_d1 = btn;
            sw_d2  = sw_d1;
            sw_d1  = sw;
        end
        #1;
        chk("valid", o_inst_valid, q.size() > 0);
        if (q.size() > 0) chk("inst", o_inst, q[0]);
        chk("level", o_btn_level, {m_level[1], m_level[0]});
        chk("evt_cnt", o_evt_cnt, m_cnt & 255);
        chk("overflow", o_overflow, m_ovf);
        snap_v    = o_inst_valid && rst_n;
        snap_inst = o_inst;
        if (|o_btn_level) lvl_seen = 1;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        popped.delete();
        pop_n.delete();
        nvalid = 0;
        lvl_seen = 0;
    endtask

    task automatic press(input logic [5:0] v);
        sw = v;
        btn[0] = 1'b1;
        cyc(16);
        btn[0] = 1'b0;
        cyc(16);
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;

        // 1: single held press, sequencer always ready
        sw = 6'h15;
        ready = 1'b1;
        do_reset();
        btn[0] = 1'b1;
        cyc(40);
        btn[0] = 1'b0;
        cyc(20);
        chk("t1 valid_cycles", nvalid, 1);
        chk("t1 pops", popped.size(), 1);
        if (popped.size() > 0) chk("t1 word", popped[0], 8'h15);
        chk("t1 evt_cnt", o_evt_cnt, 8'd1);

        // 2: glitches of one and two sample periods, then a fast bounce
        do_reset();
        btn[0] = 1'b1; cyc(4);
        btn[0] = 1'b0; cyc(16);
        btn[0] = 1'b1; cyc(8);
        btn[0] = 1'b0; cyc(16);
        for (int i = 0; i < 6; i++) begin
            btn[0] = ~btn[0];
            cyc(1);
        end
        btn[0] = 1'b0;
        cyc(20);
        chk("t2 level_seen", lvl_seen, 0);
        chk("t2 pops", popped.size(), 0);
        chk("t2 evt_cnt", o_evt_cnt, 8'd0);

        // 3: both channels rise together
        sw = 6'h0A;
        do_reset();
        btn = 2'b11;
        cyc(40);
        btn = 2'b00;
        cyc(20);
        chk("t3 pops", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t3 first", popped[0], 8'h0A);
            chk("t3 second", popped[1], 8'hCA);
            chk("t3 back_to_back", pop_n[1] - pop_n[0], 1);
        end
        chk("t3 evt_cnt", o_evt_cnt, 8'd2);

        // 4: five presses into a stalled four-entry FIFO
        ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) press(6'(i));
        chk("t4 overflow", o_overflow, 1);
        chk("t4 valid", o_inst_valid, 1);
        chk("t4 head", o_inst, 8'h01);
        ready = 1'b1;
        cyc(10);
        chk("t4 pops", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("t4 order", popped[i], 32'(i + 1));
        chk("t4 evt_cnt", o_evt_cnt, 8'd4);
        chk("t4 overflow_sticky", o_overflow, 1);

        // 5: full FIFO popped on exactly the edge a new word is pushed
        ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) press(6'(i));
        sw = 6'h05;
        btn[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1 found = o_btn_level[0];
        end
        chk("t5 level_rise", found, 1);
        cyc(3);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        cyc(12);
        btn[0] = 1'b0;
        cyc(20);
        chk("t5 overflow", o_overflow, 0);
        ready = 1'b1;
        cyc(10);
        chk("t5 pops", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("t5 order", popped[i], 32'(i + 1));
        chk("t5 evt_cnt", o_evt_cnt, 8'd5);

        // 6: reset with words queued and the button still held
        do_reset();
        press(6'h07);
        ready = 1'b0;
        press(6'h01);
        sw = 6'h02;
        btn[0] = 1'b1;
        cyc(20);
        chk("t6 queued_valid", o_inst_valid, 1);
        chk("t6 evt_before", o_evt_cnt, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 rst_valid", o_inst_valid, 0);
        chk("t6 rst_evt", o_evt_cnt, 8'd0);
        chk("t6 rst_level", o_btn_level, 2'b00);
        cyc(3);
        rst_n = 1'b1;
        popped.delete();
        pop_n.delete();
        ready = 1'b1;
        cyc(40);
        chk("t6 pops", popped.size(), 1);
        if (popped.size() > 0) chk("t6 word", popped[0], 8'h02);
        chk("t6 evt_cnt", o_evt_cnt, 8'd1);
        btn[0] = 1'b0;
        cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
